// File: rtl/mem_pkg.sv
// Shared encodings, state type and access-legality check for the data-memory port.
package mem_pkg;

  localparam logic [2:0] CTRL_NONE = 3'b000;

  localparam logic [2:0] RD_LB  = 3'b001;
  localparam logic [2:0] RD_LBU = 3'b010;
  localparam logic [2:0] RD_LH  = 3'b011;
  localparam logic [2:0] RD_LHU = 3'b100;
  localparam logic [2:0] RD_LD  = 3'b101;

  localparam logic [2:0] WR_SB  = 3'b001;
  localparam logic [2:0] WR_SH  = 3'b010;
  localparam logic [2:0] WR_SW  = 3'b011;
  localparam logic [2:0] WR_SD  = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_ACCESS,
    ST_RESP
  } state_t;

  // 1 when the ctrl pair is not exactly one legal op, or the op is misaligned.
  // Range checking depends on MEM_AW and lives in the top level.
  function automatic logic ctrl_bad(input logic [2:0] rd, input logic [2:0] wr,
                                    input logic [2:0] lo);
    logic bad;
    bad = ((rd != CTRL_NONE) == (wr != CTRL_NONE));
    case (rd)
      CTRL_NONE, RD_LB, RD_LBU: ;
      RD_LH, RD_LHU:            if (lo[0])          bad = 1'b1;
      RD_LD:                    if (lo != 3'b000)   bad = 1'b1;
      default:                  bad = 1'b1;
    endcase
    case (wr)
      CTRL_NONE, WR_SB: ;
      WR_SH:   if (lo[0])           bad = 1'b1;
      WR_SW:   if (lo[1:0] != 2'b00) bad = 1'b1;
      WR_SD:   if (lo != 3'b000)    bad = 1'b1;
      default: bad = 1'b1;
    endcase
    return bad;
  endfunction

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin pick. ptr names the port that wins a tie.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic [1:0] mask,
  input  logic       ptr,
  output logic       gnt_valid,
  output logic       gnt_id
);

  logic [1:0] live;

  assign live      = req & ~mask;
  assign gnt_valid = |live;
  // A lone requester wins outright; only a tie consults the pointer.
  assign gnt_id    = (&live) ? ptr : live[1];

endmodule

// File: rtl/dm_port_arbiter.sv
// Two-port arbiter/controller for the 64-bit data-memory port: round-robin
// grant, request latch with legality check, one-cycle memory access, ack/err
// pulse and read-data capture per port.
import mem_pkg::*;

module dm_port_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 64,
  parameter int MEM_AW = 14
) (
  input  logic              clk,
  input  logic              rst,

  input  logic              p0_req,
  input  logic [2:0]        p0_rd_ctrl,
  input  logic [2:0]        p0_wr_ctrl,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  output logic              p0_ack,
  output logic              p0_err,
  output logic [DATA_W-1:0] p0_rdata,

  input  logic              p1_req,
  input  logic [2:0]        p1_rd_ctrl,
  input  logic [2:0]        p1_wr_ctrl,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  output logic              p1_ack,
  output logic              p1_err,
  output logic [DATA_W-1:0] p1_rdata,

  output logic [2:0]        dm_rd_ctrl,
  output logic [2:0]        dm_wr_ctrl,
  output logic [ADDR_W-1:0] dm_addr,
  output logic [DATA_W-1:0] dm_din,
  input  logic [DATA_W-1:0] dm_dout,

  output logic              busy
);

  state_t state;
  logic   ptr;
  logic   cur_id;
  logic   cur_err;

  logic [1:0]        arb_mask;
  logic              gnt_valid;
  logic              gnt_id;
  logic [2:0]        sel_rd;
  logic [2:0]        sel_wr;
  logic [ADDR_W-1:0] sel_addr;
  logic [DATA_W-1:0] sel_wdata;
  logic              sel_err;

  // In RESP the port being acked still holds req, so hide it from the arbiter.
  assign arb_mask = (state == ST_RESP) ? (cur_id ? 2'b10 : 2'b01) : 2'b00;

  rr_arb2 u_arb (
    .req       ({p1_req, p0_req}),
    .mask      (arb_mask),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_id    (gnt_id)
  );

  assign sel_rd    = gnt_id ? p1_rd_ctrl : p0_rd_ctrl;
  assign sel_wr    = gnt_id ? p1_wr_ctrl : p0_wr_ctrl;
  assign sel_addr  = gnt_id ? p1_addr    : p0_addr;
  assign sel_wdata = gnt_id ? p1_wdata   : p0_wdata;
  assign sel_err   = (|sel_addr[ADDR_W-1:MEM_AW]) | ctrl_bad(sel_rd, sel_wr, sel_addr[2:0]);

  assign busy = (state != ST_IDLE);

  // Control FSM; dm_* double as the request latch and are zero outside ACCESS.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      ptr        <= 1'b0;
      cur_id     <= 1'b0;
      cur_err    <= 1'b0;
      p0_ack     <= 1'b0;
      p0_err     <= 1'b0;
      p0_rdata   <= '0;
      p1_ack     <= 1'b0;
      p1_err     <= 1'b0;
      p1_rdata   <= '0;
      dm_rd_ctrl <= CTRL_NONE;
      dm_wr_ctrl <= CTRL_NONE;
      dm_addr    <= '0;
      dm_din     <= '0;
    end else begin
      p0_ack <= 1'b0;
      p0_err <= 1'b0;
      p1_ack <= 1'b0;
      p1_err <= 1'b0;
      case (state)
        ST_IDLE, ST_RESP: begin
          if (gnt_valid) begin
            state   <= ST_ACCESS;
            ptr     <= ~gnt_id;
            cur_id  <= gnt_id;
            cur_err <= sel_err;
            // A rejected request still takes its ACCESS slot but never reaches memory.
            dm_rd_ctrl <= sel_err ? CTRL_NONE : sel_rd;
            dm_wr_ctrl <= sel_err ? CTRL_NONE : sel_wr;
            dm_addr    <= sel_err ? '0 : sel_addr;
            dm_din     <= sel_err ? '0 : sel_wdata;
          end else begin
            state <= ST_IDLE;
          end
        end
        ST_ACCESS: begin
          state      <= ST_RESP;
          dm_rd_ctrl <= CTRL_NONE;
          dm_wr_ctrl <= CTRL_NONE;
          dm_addr    <= '0;
          dm_din     <= '0;
          // dm_rd_ctrl is already zero for stores and rejected requests.
          if (cur_id) begin
            p1_ack   <= 1'b1;
            p1_err   <= cur_err;
            p1_rdata <= (dm_rd_ctrl != CTRL_NONE) ? dm_dout : '0;
          end else begin
            p0_ack   <= 1'b1;
            p0_err   <= cur_err;
            p0_rdata <= (dm_rd_ctrl != CTRL_NONE) ? dm_dout : '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
